dma_bus_control_param: RTL and testbench

DMA_BUS_CONTROL_PARAM -- requirements
Module: dma_bus_control_param

---
 rtl/dma_bus_control_param.sv | 160 ++++++++++++++++
 tb/tb_dma_bus_control_param.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_control_param.sv
// DMA bus control: CPU register decode, write/read completion strobes and the byte-pointer flip-flop.
// Define DMA_BUS_INPUT_SYNC_EN to pass chip select and the read/write strobes through two-flop synchronisers.
module dma_bus_control_param #(
   parameter int CHANNELS = 4,
   parameter int ADDR_W   = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                chip_select_n,
   input  logic                io_read_n_in,
   input  logic                io_write_n_in,
   input  logic [ADDR_W-1:0]   address_in,
   input  logic [7:0]          data_bus_in,
   input  logic                lock_bus_control,
   output logic [7:0]          internal_data_bus,
   output logic                byte_pointer,
   output logic                write_command_register,
   output logic                write_mode_register,
   output logic                write_request_register,
   output logic                set_or_reset_mask_register,
   output logic                write_mask_register,
   output logic                clear_mask_register,
   output logic                master_clear,
   output logic                clear_byte_pointer,
   output logic                set_byte_pointer,
   output logic [CHANNELS-1:0] write_base_and_current_address,
   output logic [CHANNELS-1:0] write_base_and_current_word_count,
   output logic [CHANNELS-1:0] read_current_address,
   output logic [CHANNELS-1:0] read_current_word_count,
   output logic                read_status_register,
   output logic                read_temporary_register
);
   localparam int unsigned CTRL_BASE = 2 * CHANNELS;

   if (!(CHANNELS == 4 || CHANNELS == 8)) begin : g_bad_channels
      $error("dma_bus_control_param: CHANNELS must be 4 or 8");
   end
   if (ADDR_W != $clog2(2 * CHANNELS) + 1) begin : g_bad_addr_w
      $error("dma_bus_control_param: ADDR_W must equal log2(2*CHANNELS)+1");
   end

   logic cs_n_s, rd_n_s, wr_n_s;

`ifdef DMA_BUS_INPUT_SYNC_EN
   logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;

   always_comb begin
      sync1_d = {chip_select_n, io_read_n_in, io_write_n_in};
      sync2_d = sync1_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign {cs_n_s, rd_n_s, wr_n_s} = sync2_q;
`else
   assign {cs_n_s, rd_n_s, wr_n_s} = {chip_select_n, io_read_n_in, io_write_n_in};
`endif

   logic [7:0]          data_q, data_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                prev_wr_q, prev_wr_d;
   logic                prev_rd_q, prev_rd_d;
   logic                bp_q, bp_d;
   logic [7:0]          ctrl_q, ctrl_d;
   logic                set_bp_q, set_bp_d;
   logic [CHANNELS-1:0] chan_addr_q, chan_addr_d;
   logic [CHANNELS-1:0] chan_cnt_q, chan_cnt_d;
   logic                wr_done, rd_done, rd_active, wr_to_chan, rd_from_chan;

   always_comb begin
      data_d = data_q;
      addr_d = addr_q;
      // Capture uses the raw strobes so data and address stay aligned with the bus.
      if (!chip_select_n && !io_write_n_in) begin
         data_d = data_bus_in;
         addr_d = address_in;
      end

      // A deselect forces history high, which aborts a pending write/read and re-arms detection.
      prev_wr_d = cs_n_s | wr_n_s;
      prev_rd_d = cs_n_s | rd_n_s;
      wr_done   = !lock_bus_control && !cs_n_s && wr_n_s && !prev_wr_q;
      rd_done   = !lock_bus_control && !cs_n_s && rd_n_s && !prev_rd_q;
      rd_active = !lock_bus_control && !cs_n_s && !rd_n_s;

      ctrl_d                  = '0;
      chan_addr_d             = '0;
      chan_cnt_d              = '0;
      read_current_address    = '0;
      read_current_word_count = '0;
      for (int unsigned n = 0; n < CHANNELS; n++) begin
         if (wr_done && addr_q == ADDR_W'(2 * n))         chan_addr_d[n] = 1'b1;
         if (wr_done && addr_q == ADDR_W'(2 * n + 1))     chan_cnt_d[n]  = 1'b1;
         if (rd_active && address_in == ADDR_W'(2 * n))     read_current_address[n]    = 1'b1;
         if (rd_active && address_in == ADDR_W'(2 * n + 1)) read_current_word_count[n] = 1'b1;
      end
      for (int unsigned k = 0; k < 8; k++) begin
         if (wr_done && addr_q == ADDR_W'(CTRL_BASE + k)) ctrl_d[k] = 1'b1;
      end
      read_status_register    = rd_active && (address_in == ADDR_W'(CTRL_BASE));
      read_temporary_register = rd_active && (address_in == ADDR_W'(CTRL_BASE + 5));

      wr_to_chan   = wr_done && (addr_q < ADDR_W'(CTRL_BASE));
      rd_from_chan = rd_done && (address_in < ADDR_W'(CTRL_BASE));
      set_bp_d     = rd_done && (address_in == ADDR_W'(CTRL_BASE + 4));

      // Priority: clear over set over toggle.
      bp_d = bp_q;
      if (wr_to_chan || rd_from_chan) bp_d = !bp_q;
      if (set_bp_d)                   bp_d = 1'b1;
      if (ctrl_d[4] || ctrl_d[5])     bp_d = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_q      <= '0;
         addr_q      <= '0;
         prev_wr_q   <= 1'b1;
         prev_rd_q   <= 1'b1;
         bp_q        <= 1'b0;
         ctrl_q      <= '0;
         set_bp_q    <= 1'b0;
         chan_addr_q <= '0;
         chan_cnt_q  <= '0;
      end else begin
         data_q      <= data_d;
         addr_q      <= addr_d;
         prev_wr_q   <= prev_wr_d;
         prev_rd_q   <= prev_rd_d;
         bp_q        <= bp_d;
         ctrl_q      <= ctrl_d;
         set_bp_q    <= set_bp_d;
         chan_addr_q <= chan_addr_d;
         chan_cnt_q  <= chan_cnt_d;
      end
   end

   assign internal_data_bus                 = data_q;
   assign byte_pointer                      = bp_q;
   assign write_command_register            = ctrl_q[0];
   assign write_request_register            = ctrl_q[1];
   assign set_or_reset_mask_register        = ctrl_q[2];
   assign write_mode_register               = ctrl_q[3];
   assign clear_byte_pointer                = ctrl_q[4];
   assign master_clear                      = ctrl_q[5];
   assign clear_mask_register               = ctrl_q[6];
   assign write_mask_register               = ctrl_q[7];
   assign set_byte_pointer                  = set_bp_q;
   assign write_base_and_current_address    = chan_addr_q;
   assign write_base_and_current_word_count = chan_cnt_q;

endmodule

// File: tb/tb_dma_bus_control_param.sv
// Bench for dma_bus_control_param: 4- and 8-channel instances share the bus strobes, checked
// against a transaction-level register-map model.
module tb_dma_bus_control_param;
   `ifdef DMA_BUS_INPUT_SYNC_EN
   localparam int SYNC = 2;
   `else
   localparam int SYNC = 0;
   `endif

   logic       clk = 1'b0;
   logic       rst, cs_n, rd_n, wr_n, lock;
   logic [3:0] addr4;
   logic [4:0] addr8;
   logic [7:0] data;

   logic [7:0] idb4, idb8;
   logic       bp4o, bp8o;
   logic       cmd4, mode4, req4, smask4, wmask4, cmask4, mclr4, clrbp4, setbp4, rs4, rt4;
   logic       cmd8, mode8, req8, smask8, wmask8, cmask8, mclr8, clrbp8, setbp8, rs8, rt8;
   logic [3:0] wadr4, wcnt4, rca4, rcwc4;
   logic [7:0] wadr8, wcnt8, rca8, rcwc8;

   int n_checks = 0;
   int n_fail   = 0;
   logic bp4m, bp8m;

   always #5 clk = ~clk;

   dma_bus_control_param #(.CHANNELS(4), .ADDR_W(4)) u_dut4 (
      .clock(clk), .reset(rst), .chip_select_n(cs_n), .io_read_n_in(rd_n), .io_write_n_in(wr_n),
      .address_in(addr4), .data_bus_in(data), .lock_bus_control(lock),
      .internal_data_bus(idb4), .byte_pointer(bp4o),
      .write_command_register(cmd4), .write_mode_register(mode4), .write_request_register(req4),
      .set_or_reset_mask_register(smask4), .write_mask_register(wmask4), .clear_mask_register(cmask4),
      .master_clear(mclr4), .clear_byte_pointer(clrbp4), .set_byte_pointer(setbp4),
      .write_base_and_current_address(wadr4), .write_base_and_current_word_count(wcnt4),
      .read_current_address(rca4), .read_current_word_count(rcwc4),
      .read_status_register(rs4), .read_temporary_register(rt4));

   dma_bus_control_param #(.CHANNELS(8), .ADDR_W(5)) u_dut8 (
      .clock(clk), .reset(rst), .chip_select_n(cs_n), .io_read_n_in(rd_n), .io_write_n_in(wr_n),
      .address_in(addr8), .data_bus_in(data), .lock_bus_control(lock),
      .internal_data_bus(idb8), .byte_pointer(bp8o),
      .write_command_register(cmd8), .write_mode_register(mode8), .write_request_register(req8),
      .set_or_reset_mask_register(smask8), .write_mask_register(wmask8), .clear_mask_register(cmask8),
      .master_clear(mclr8), .clear_byte_pointer(clrbp8), .set_byte_pointer(setbp8),
      .write_base_and_current_address(wadr8), .write_base_and_current_word_count(wcnt8),
      .read_current_address(rca8), .read_current_word_count(rcwc8),
      .read_status_register(rs8), .read_temporary_register(rt8));

   // Strobe view: [7:0] channel address, [15:8] word count, [16] set_bp, [24:17] control offsets 0..7.
   logic [31:0] st4, st8, lv4, lv8;
   assign st4 = {7'd0, wmask4, cmask4, mclr4, clrbp4, mode4, smask4, req4, cmd4, setbp4,
                 4'd0, wcnt4, 4'd0, wadr4};
   assign st8 = {7'd0, wmask8, cmask8, mclr8, clrbp8, mode8, smask8, req8, cmd8, setbp8, wcnt8, wadr8};
   // Level view: [7:0] current address, [15:8] word count, [16] status, [17] temporary.
   assign lv4 = {14'd0, rt4, rs4, 4'd0, rcwc4, 4'd0, rca4};
   assign lv8 = {14'd0, rt8, rs8, rcwc8, rca8};

   function automatic logic [31:0] exp_wr(input int unsigned ch, input int unsigned a);
      logic [31:0] v;
      int unsigned c;
      v = '0;
      c = 2 * ch;
      if (a < c) begin
         if (a % 2 == 0) v[a / 2] = 1'b1;
         else            v[8 + a / 2] = 1'b1;
      end else if (a < c + 8) begin
         v[17 + (a - c)] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic exp_wr_bp(input int unsigned ch, input int unsigned a, input logic bp);
      if (a < 2 * ch) return !bp;
      if (a == 2 * ch + 4 || a == 2 * ch + 5) return 1'b0;
      return bp;
   endfunction

   function automatic logic [31:0] exp_lv(input int unsigned ch, input int unsigned a);
      logic [31:0] v;
      v = '0;
      if (a < 2 * ch) begin
         if (a % 2 == 0) v[a / 2] = 1'b1;
         else            v[8 + a / 2] = 1'b1;
      end else if (a == 2 * ch)     v[16] = 1'b1;
      else if (a == 2 * ch + 5)     v[17] = 1'b1;
      return v;
   endfunction

   function automatic logic [31:0] exp_rd_st(input int unsigned ch, input int unsigned a);
      logic [31:0] v;
      v = '0;
      if (a == 2 * ch + 4) v[16] = 1'b1;
      return v;
   endfunction

   function automatic logic exp_rd_bp(input int unsigned ch, input int unsigned a, input logic bp);
      if (a < 2 * ch) return !bp;
      if (a == 2 * ch + 4) return 1'b1;
      return bp;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [3:0] a4, input logic [4:0] a8, input logic [7:0] d);
      logic [31:0] e4, e8;
      cs_n = 1'b0; wr_n = 1'b0; addr4 = a4; addr8 = a8; data = d;
      tick(1);
      wr_n = 1'b1;
      tick(SYNC + 1);
      e4 = lock ? '0 : exp_wr(4, a4);
      e8 = lock ? '0 : exp_wr(8, a8);
      if (!lock) begin
         bp4m = exp_wr_bp(4, a4, bp4m);
         bp8m = exp_wr_bp(8, a8, bp8m);
      end
      chk("wr_strobe_c4", st4, e4);
      chk("wr_strobe_c8", st8, e8);
      chk("wr_bp_c4", 32'(bp4o), 32'(bp4m));
      chk("wr_bp_c8", 32'(bp8o), 32'(bp8m));
      chk("wr_data_c4", 32'(idb4), 32'(d));
      chk("wr_data_c8", 32'(idb8), 32'(d));
      cs_n = 1'b1;
      tick(1);
      chk("wr_pulse_end_c4", st4, '0);
      chk("wr_pulse_end_c8", st8, '0);
      tick(SYNC + 1);
   endtask

   task automatic do_read(input logic [3:0] a4, input logic [4:0] a8);
      cs_n = 1'b0; rd_n = 1'b0; addr4 = a4; addr8 = a8;
      tick(SYNC + 1);
      chk("rd_level_c4", lv4, lock ? '0 : exp_lv(4, a4));
      chk("rd_level_c8", lv8, lock ? '0 : exp_lv(8, a8));
      rd_n = 1'b1;
      tick(SYNC + 1);
      if (!lock) begin
         bp4m = exp_rd_bp(4, a4, bp4m);
         bp8m = exp_rd_bp(8, a8, bp8m);
      end
      chk("rd_done_strobe_c4", st4, lock ? '0 : exp_rd_st(4, a4));
      chk("rd_done_strobe_c8", st8, lock ? '0 : exp_rd_st(8, a8));
      chk("rd_bp_c4", 32'(bp4o), 32'(bp4m));
      chk("rd_bp_c8", 32'(bp8o), 32'(bp8m));
      chk("rd_level_off_c4", lv4, '0);
      chk("rd_level_off_c8", lv8, '0);
      cs_n = 1'b1;
      tick(1);
      chk("rd_pulse_end_c4", st4, '0);
      chk("rd_pulse_end_c8", st8, '0);
      tick(SYNC + 1);
   endtask

   initial begin
      rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; lock = 1'b0;
      addr4 = '0; addr8 = '0; data = '0;
      bp4m = 1'b0; bp8m = 1'b0;
      tick(2);
      chk("reset_strobe_c4", st4, '0);
      chk("reset_strobe_c8", st8, '0);
      chk("reset_bp_c4", 32'(bp4o), 32'd0);
      chk("reset_bp_c8", 32'(bp8o), 32'd0);
      chk("reset_data_c4", 32'(idb4), 32'd0);
      chk("reset_data_c8", 32'(idb8), 32'd0);
      rst = 1'b0;
      tick(1);

      do_write(4'h2, 5'h02, 8'h5A);   // channel 1 address write
      do_write(4'hB, 5'h13, 8'hC3);   // mode register
      do_write(4'hC, 5'h14, 8'h00);   // clear byte pointer
      do_read(4'h7, 5'h07);
      do_read(4'h7, 5'h07);

      // Clear-byte-pointer write completing on the same edge as a channel read-done.
      do_write(4'h0, 5'h00, 8'h11);
      cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0; addr4 = 4'hC; addr8 = 5'h14; data = 8'h33;
      tick(1);
      wr_n = 1'b1; rd_n = 1'b1; addr4 = 4'h0; addr8 = 5'h00;
      tick(SYNC + 1);
      bp4m = 1'b0; bp8m = 1'b0;
      chk("coincide_strobe_c4", st4, exp_wr(4, 12));
      chk("coincide_strobe_c8", st8, exp_wr(8, 20));
      chk("coincide_bp_c4", 32'(bp4o), 32'(bp4m));
      chk("coincide_bp_c8", 32'(bp8o), 32'(bp8m));
      cs_n = 1'b1;
      tick(SYNC + 2);

      lock = 1'b1;
      do_write(4'h0, 5'h00, 8'h77);
      do_read(4'h1, 5'h01);
      lock = 1'b0;

      // Deselect while the write strobe is still low, then reselect with it high.
      cs_n = 1'b0; wr_n = 1'b0; addr4 = 4'h1; addr8 = 5'h01; data = 8'h99;
      tick(1);
      cs_n = 1'b1;
      tick(1);
      wr_n = 1'b1;
      tick(1);
      cs_n = 1'b0;
      tick(SYNC + 1);
      chk("abort_strobe_c4", st4, '0);
      chk("abort_strobe_c8", st8, '0);
      chk("abort_bp_c4", 32'(bp4o), 32'(bp4m));
      chk("abort_bp_c8", 32'(bp8o), 32'(bp8m));
      cs_n = 1'b1;
      tick(SYNC + 1);

      do_write(4'hF, 5'h18, 8'hA5);   // c4 write-all-mask, c8 beyond map
      do_write(4'h8, 5'h1F, 8'h3C);   // c4 command, c8 beyond map
      do_read(4'hC, 5'h14);           // byte-pointer set via read-done
      do_write(4'hD, 5'h15, 8'h00);   // master clear
      do_read(4'h8, 5'h10);           // status
      do_read(4'hD, 5'h1D);

      for (int i = 0; i < 60; i++) begin
         lock = ($urandom_range(7) == 0);
         if ($urandom_range(1) == 0)
            do_write(4'($urandom_range(15)), 5'($urandom_range(31)), 8'($urandom_range(255)));
         else
            do_read(4'($urandom_range(15)), 5'($urandom_range(31)));
      end
      lock = 1'b0;

      // Reset landing between write capture and completion.
      cs_n = 1'b0; wr_n = 1'b0; addr4 = 4'h2; addr8 = 5'h02; data = 8'hE7;
      tick(1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0; wr_n = 1'b1;
      bp4m = 1'b0; bp8m = 1'b0;
      tick(SYNC + 1);
      chk("rst_mid_strobe_c4", st4, '0);
      chk("rst_mid_strobe_c8", st8, '0);
      chk("rst_mid_bp_c4", 32'(bp4o), 32'(bp4m));
      chk("rst_mid_bp_c8", 32'(bp8o), 32'(bp8m));
      chk("rst_mid_data_c4", 32'(idb4), 32'd0);
      chk("rst_mid_data_c8", 32'(idb8), 32'd0);
      cs_n = 1'b1;
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
